// File: rtl/ctrl_pipe.sv
// Pipelined control decoder for the pd5 core: decodes into X, carries fields through M and W,
// detects load-use stalls and squashes on flush. Optional macro: CTRL_ILLEGAL_TRAP_EN.
module ctrl_pipe #(
   parameter int DWIDTH = 32,
   parameter int RWIDTH = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] insn_i,
   input  logic              insn_valid_i,
   output logic              insn_ready_o,
   input  logic              flush_i,
   output logic              x_valid_o,
   output logic [3:0]        x_alusel_o,
   output logic              x_immsel_o,
   output logic              x_rs1sel_o,
   output logic              x_rs2sel_o,
   output logic              x_pcsel_o,
   output logic [RWIDTH-1:0] x_rs1_o,
   output logic [RWIDTH-1:0] x_rs2_o,
   output logic [RWIDTH-1:0] x_rd_o,
   output logic              m_valid_o,
   output logic              m_memren_o,
   output logic              m_memwren_o,
   output logic [2:0]        m_funct3_o,
   output logic [RWIDTH-1:0] m_rd_o,
   output logic              w_valid_o,
   output logic              w_regwren_o,
   output logic [1:0]        w_wbsel_o,
   output logic [RWIDTH-1:0] w_rd_o,
   output logic              illegal_o
);

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IALU   = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PCADD = 4'd10;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_JAL = 2'd2;

   typedef struct packed {
      logic              valid;
      logic              illegal;
      logic [3:0]        alusel;
      logic              immsel;
      logic              rs1sel;
      logic              rs2sel;
      logic              pcsel;
      logic [RWIDTH-1:0] rs1;
      logic [RWIDTH-1:0] rs2;
      logic [RWIDTH-1:0] rd;
      logic              memren;
      logic              memwren;
      logic [2:0]        funct3;
      logic              regwren;
      logic [1:0]        wbsel;
   } x_ent_t;

   typedef struct packed {
      logic              valid;
      logic              illegal;
      logic              memren;
      logic              memwren;
      logic [2:0]        funct3;
      logic [RWIDTH-1:0] rd;
      logic              regwren;
      logic [1:0]        wbsel;
   } m_ent_t;

   typedef struct packed {
      logic              valid;
      logic              illegal;
      logic              regwren;
      logic [1:0]        wbsel;
      logic [RWIDTH-1:0] rd;
   } w_ent_t;

   x_ent_t x_q, x_d, dec;
   m_ent_t m_q, m_d;
   w_ent_t w_q, w_d;

   logic [6:0]        opcode;
   logic [6:0]        funct7;
   logic [2:0]        funct3;
   logic [RWIDTH-1:0] rs1_f;
   logic [RWIDTH-1:0] rs2_f;
   logic [RWIDTH-1:0] rd_f;
   logic [3:0]        alu_sel;
   logic              f7_bad;
   logic              op_known;
   logic              use_rs1;
   logic              use_rs2;
   logic              load_use;
   logic              accept;

   assign opcode = insn_i[6:0];
   assign funct3 = insn_i[14:12];
   assign funct7 = insn_i[31:25];
   assign rs1_f  = RWIDTH'(insn_i[19:15]);
   assign rs2_f  = RWIDTH'(insn_i[24:20]);
   assign rd_f   = RWIDTH'(insn_i[11:7]);

   // funct7 only qualifies R-type ops and immediate shifts; ADDI etc. carry immediate bits there
   always_comb begin
      alu_sel = ALU_ADD;
      f7_bad  = 1'b0;
      case (funct3)
         3'd0: begin
            if (opcode == OP_R) begin
               if (funct7 == 7'h20)      alu_sel = ALU_SUB;
               else if (funct7 != 7'h00) f7_bad  = 1'b1;
            end
         end
         3'd1: begin
            alu_sel = ALU_SLL;
            f7_bad  = (funct7 != 7'h00);
         end
         3'd2: begin
            alu_sel = ALU_SLT;
            f7_bad  = (opcode == OP_R) && (funct7 != 7'h00);
         end
         3'd3: begin
            alu_sel = ALU_SLTU;
            f7_bad  = (opcode == OP_R) && (funct7 != 7'h00);
         end
         3'd4: begin
            alu_sel = ALU_XOR;
            f7_bad  = (opcode == OP_R) && (funct7 != 7'h00);
         end
         3'd5: begin
            if (funct7 == 7'h00)      alu_sel = ALU_SRL;
            else if (funct7 == 7'h20) alu_sel = ALU_SRA;
            else                      f7_bad  = 1'b1;
         end
         3'd6: begin
            alu_sel = ALU_OR;
            f7_bad  = (opcode == OP_R) && (funct7 != 7'h00);
         end
         default: begin
            alu_sel = ALU_AND;
            f7_bad  = (opcode == OP_R) && (funct7 != 7'h00);
         end
      endcase
      if (f7_bad) alu_sel = ALU_ADD;
   end

   always_comb begin
      dec      = '0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      op_known = 1'b1;
      case (opcode)
         OP_R: begin
            dec.alusel  = alu_sel;
            dec.regwren = 1'b1;
            dec.wbsel   = WB_ALU;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
         end
         OP_IALU: begin
            dec.alusel  = alu_sel;
            dec.immsel  = 1'b1;
            dec.rs2sel  = 1'b1;
            dec.regwren = 1'b1;
            dec.wbsel   = WB_ALU;
            use_rs1     = 1'b1;
         end
         OP_LOAD: begin
            dec.alusel  = ALU_ADD;
            dec.immsel  = 1'b1;
            dec.rs2sel  = 1'b1;
            dec.memren  = 1'b1;
            dec.wbsel   = WB_MEM;
            dec.regwren = 1'b1;
            use_rs1     = 1'b1;
         end
         OP_STORE: begin
            dec.alusel  = ALU_ADD;
            dec.immsel  = 1'b1;
            dec.rs2sel  = 1'b1;
            dec.memwren = 1'b1;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
         end
         OP_BRANCH: begin
            dec.alusel  = ALU_PCADD;
            dec.immsel  = 1'b1;
            dec.rs1sel  = 1'b1;
            dec.rs2sel  = 1'b1;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
         end
         OP_JAL: begin
            dec.alusel  = ALU_PCADD;
            dec.rs1sel  = 1'b1;
            dec.rs2sel  = 1'b1;
            dec.pcsel   = 1'b1;
            dec.wbsel   = WB_JAL;
            dec.regwren = 1'b1;
         end
         OP_JALR: begin
            dec.alusel  = ALU_ADD;
            dec.rs2sel  = 1'b1;
            dec.pcsel   = 1'b1;
            dec.wbsel   = WB_JAL;
            dec.regwren = 1'b1;
            use_rs1     = 1'b1;
         end
         OP_LUI: begin
            dec.alusel  = ALU_ADD;
            dec.rs2sel  = 1'b1;
            dec.regwren = 1'b1;
         end
         OP_AUIPC: begin
            dec.alusel  = ALU_ADD;
            dec.rs1sel  = 1'b1;
            dec.rs2sel  = 1'b1;
            dec.regwren = 1'b1;
         end
         default: op_known = 1'b0;
      endcase
      dec.valid  = 1'b1;
      dec.rs1    = (opcode == OP_LUI) ? '0 : rs1_f;
      dec.rs2    = rs2_f;
      dec.rd     = rd_f;
      dec.funct3 = funct3;
      if (rd_f == '0) dec.regwren = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (!op_known || ((opcode == OP_R || opcode == OP_IALU) && f7_bad)) begin
         dec         = '0;
         dec.valid   = 1'b1;
         dec.illegal = 1'b1;
      end
`else
      if (!op_known) dec = '0;
`endif
   end

   // only a LOAD sitting in X sets memren there, so memren doubles as the "X is LOAD" flag
   assign load_use = x_q.valid && x_q.memren && (x_q.rd != '0) &&
                     ((use_rs1 && (rs1_f == x_q.rd)) || (use_rs2 && (rs2_f == x_q.rd)));

   assign insn_ready_o = !reset && (flush_i || !load_use);
   assign accept       = insn_valid_i && insn_ready_o;

   always_comb begin
      x_d = (accept && !flush_i) ? dec : '0;

      m_d         = '0;
      m_d.valid   = x_q.valid;
      m_d.illegal = x_q.illegal;
      m_d.memren  = x_q.memren;
      m_d.memwren = x_q.memwren;
      m_d.funct3  = x_q.funct3;
      m_d.rd      = x_q.rd;
      m_d.regwren = x_q.regwren;
      m_d.wbsel   = x_q.wbsel;

      w_d         = '0;
      w_d.valid   = m_q.valid;
      w_d.illegal = m_q.illegal;
      w_d.regwren = m_q.regwren;
      w_d.wbsel   = m_q.wbsel;
      w_d.rd      = m_q.rd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         x_q <= x_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign x_valid_o   = x_q.valid;
   assign x_alusel_o  = x_q.alusel;
   assign x_immsel_o  = x_q.immsel;
   assign x_rs1sel_o  = x_q.rs1sel;
   assign x_rs2sel_o  = x_q.rs2sel;
   assign x_pcsel_o   = x_q.pcsel;
   assign x_rs1_o     = x_q.rs1;
   assign x_rs2_o     = x_q.rs2;
   assign x_rd_o      = x_q.rd;
   assign m_valid_o   = m_q.valid;
   assign m_memren_o  = m_q.memren;
   assign m_memwren_o = m_q.memwren;
   assign m_funct3_o  = m_q.funct3;
   assign m_rd_o      = m_q.rd;
   assign w_valid_o   = w_q.valid;
   assign w_regwren_o = w_q.regwren;
   assign w_wbsel_o   = w_q.wbsel;
   assign w_rd_o      = w_q.rd;
   // the illegal flag is never set when the trap is compiled out, so this stays low
   assign illegal_o   = w_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus random traffic against a table-driven decode
// model and a three-slot pipeline history.
module tb_ctrl_pipe;
   localparam int DW = 32;
   localparam int RW = 5;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                          A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9,
                          A_PCADD = 4'd10;
   localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_JAL = 2'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, insn_valid_i, insn_ready_o, flush_i;
   logic [DW-1:0] insn_i;
   logic          x_valid_o, x_immsel_o, x_rs1sel_o, x_rs2sel_o, x_pcsel_o;
   logic [3:0]    x_alusel_o;
   logic [RW-1:0] x_rs1_o, x_rs2_o, x_rd_o, m_rd_o, w_rd_o;
   logic          m_valid_o, m_memren_o, m_memwren_o;
   logic [2:0]    m_funct3_o;
   logic          w_valid_o, w_regwren_o, illegal_o;
   logic [1:0]    w_wbsel_o;

   ctrl_pipe #(.DWIDTH(DW), .RWIDTH(RW)) dut (
      .clk(clk), .reset(reset), .insn_i(insn_i), .insn_valid_i(insn_valid_i),
      .insn_ready_o(insn_ready_o), .flush_i(flush_i),
      .x_valid_o(x_valid_o), .x_alusel_o(x_alusel_o), .x_immsel_o(x_immsel_o),
      .x_rs1sel_o(x_rs1sel_o), .x_rs2sel_o(x_rs2sel_o), .x_pcsel_o(x_pcsel_o),
      .x_rs1_o(x_rs1_o), .x_rs2_o(x_rs2_o), .x_rd_o(x_rd_o),
      .m_valid_o(m_valid_o), .m_memren_o(m_memren_o), .m_memwren_o(m_memwren_o),
      .m_funct3_o(m_funct3_o), .m_rd_o(m_rd_o),
      .w_valid_o(w_valid_o), .w_regwren_o(w_regwren_o), .w_wbsel_o(w_wbsel_o),
      .w_rd_o(w_rd_o), .illegal_o(illegal_o)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       valid;
      logic [3:0] alu;
      logic       imm, s1, s2, pcs;
      logic [4:0] rs1, rs2, rd;
      logic       mr, mw;
      logic [2:0] f3;
      logic       rw;
      logic [1:0] wb;
      logic       ill;
      logic       ld;
   } ent_t;

   typedef struct {
      logic        r, v, fl;
      logic [31:0] ins;
   } stim_t;

   ent_t pipe [3];   // index 0 = X, 1 = M, 2 = W
   logic exp_rdy;
   logic cur_rst, cur_v, cur_fl;
   logic [31:0] cur_ins;

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic is_r, output logic bad);
      logic [3:0] base;
      logic       f7_matters;
      bad = 1'b0;
      case (f3)
         3'd0: base = A_ADD;  3'd1: base = A_SLL;  3'd2: base = A_SLT; 3'd3: base = A_SLTU;
         3'd4: base = A_XOR;  3'd5: base = A_SRL;  3'd6: base = A_OR;  default: base = A_AND;
      endcase
      f7_matters = is_r || f3 == 3'd1 || f3 == 3'd5;
      if (!f7_matters || f7 == 7'h00) return base;
      if (f7 == 7'h20 && ((f3 == 3'd0 && is_r) || f3 == 3'd5)) return (f3 == 3'd0) ? A_SUB : A_SRA;
      bad = 1'b1;
      return A_ADD;
   endfunction

   function automatic void uses(input logic [31:0] ins, output logic u1, output logic u2);
      logic [6:0] op;
      op = ins[6:0];
      u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
      u2 = op inside {7'h33, 7'h23, 7'h63};
   endfunction

   function automatic ent_t ref_decode(input logic [31:0] ins);
      ent_t e;
      logic bad, known;
      e = '0; bad = 1'b0; known = 1'b1;
      case (ins[6:0])
         7'h33: begin e.alu = alu_ref(ins[14:12], ins[31:25], 1'b1, bad); e.rw = 1; e.wb = WB_ALU; end
         7'h13: begin e.alu = alu_ref(ins[14:12], ins[31:25], 1'b0, bad); e.imm = 1; e.s2 = 1; e.rw = 1; end
         7'h03: begin e.alu = A_ADD; e.imm = 1; e.s2 = 1; e.mr = 1; e.wb = WB_MEM; e.rw = 1; e.ld = 1; end
         7'h23: begin e.alu = A_ADD; e.imm = 1; e.s2 = 1; e.mw = 1; end
         7'h63: begin e.alu = A_PCADD; e.imm = 1; e.s1 = 1; e.s2 = 1; end
         7'h6f: begin e.alu = A_PCADD; e.s1 = 1; e.s2 = 1; e.pcs = 1; e.wb = WB_JAL; e.rw = 1; end
         7'h67: begin e.alu = A_ADD; e.s2 = 1; e.pcs = 1; e.wb = WB_JAL; e.rw = 1; end
         7'h37: begin e.alu = A_ADD; e.s2 = 1; e.rw = 1; end
         7'h17: begin e.alu = A_ADD; e.s1 = 1; e.s2 = 1; e.rw = 1; end
         default: known = 1'b0;
      endcase
      e.valid = 1'b1;
      e.rs1   = (ins[6:0] == 7'h37) ? 5'd0 : ins[19:15];
      e.rs2   = ins[24:20];
      e.rd    = ins[11:7];
      e.f3    = ins[14:12];
      if (e.rd == 5'd0) e.rw = 1'b0;
      if (TRAP && (!known || bad)) begin
         e = '0; e.valid = 1'b1; e.ill = 1'b1;
      end else if (!known) begin
         e = '0;
      end
      return e;
   endfunction

   function automatic logic [23:0] exp_x();
      return {pipe[0].valid, pipe[0].alu, pipe[0].imm, pipe[0].s1, pipe[0].s2, pipe[0].pcs,
              pipe[0].rs1, pipe[0].rs2, pipe[0].rd};
   endfunction
   function automatic logic [23:0] obs_x();
      return {x_valid_o, x_alusel_o, x_immsel_o, x_rs1sel_o, x_rs2sel_o, x_pcsel_o,
              x_rs1_o, x_rs2_o, x_rd_o};
   endfunction
   function automatic logic [10:0] exp_m();
      return {pipe[1].valid, pipe[1].mr, pipe[1].mw, (pipe[1].mr | pipe[1].mw) ? pipe[1].f3 : 3'd0,
              pipe[1].rd};
   endfunction
   function automatic logic [10:0] obs_m();
      return {m_valid_o, m_memren_o, m_memwren_o, (m_memren_o | m_memwren_o) ? m_funct3_o : 3'd0,
              m_rd_o};
   endfunction
   function automatic logic [9:0] exp_w();
      return {pipe[2].valid, pipe[2].rw, pipe[2].wb, pipe[2].rd, pipe[2].ill};
   endfunction
   function automatic logic [9:0] obs_w();
      return {w_valid_o, w_regwren_o, w_wbsel_o, w_rd_o, illegal_o};
   endfunction

   task automatic drive(input logic r, input logic v, input logic [31:0] ins, input logic fl);
      logic u1, u2, stall;
      @(negedge clk);
      reset = r; insn_valid_i = v; insn_i = ins; flush_i = fl;
      cur_rst = r; cur_v = v; cur_ins = ins; cur_fl = fl;
      uses(ins, u1, u2);
      stall = pipe[0].valid && pipe[0].ld && pipe[0].rd != 5'd0 &&
              ((u1 && ins[19:15] == pipe[0].rd) || (u2 && ins[24:20] == pipe[0].rd));
      exp_rdy = !r && (fl || !stall);
      #1;
   endtask

   task automatic tick();
      ent_t nw;
      @(posedge clk);
      if (cur_rst) begin
         pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      end else begin
         nw = (cur_v && exp_rdy && !cur_fl) ? ref_decode(cur_ins) : '0;
         pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = nw;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] add3;
      add3 = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
      for (int i = 0; i < 4; i++) begin
         drive(i < 3, 1'b1, (i < 3) ? $urandom : add3, 1'b0);
         checks++;
         if (insn_ready_o !== exp_rdy) begin
            errors++; $display("FAIL reset_ready[%0d]: got %b want %b", i, insn_ready_o, exp_rdy);
         end
         tick();
         checks++;
         if (obs_x() !== exp_x()) begin errors++; $display("FAIL reset_x[%0d]: got %h want %h", i, obs_x(), exp_x()); end
         checks++;
         if (obs_m() !== exp_m()) begin errors++; $display("FAIL reset_m[%0d]: got %h want %h", i, obs_m(), exp_m()); end
         checks++;
         if (obs_w() !== exp_w()) begin errors++; $display("FAIL reset_w[%0d]: got %h want %h", i, obs_w(), exp_w()); end
         if (i == 3) begin
            checks++;
            if (x_valid_o !== 1'b1) begin errors++; $display("FAIL first_accept: got %b want 1", x_valid_o); end
         end
      end
   endtask

   task automatic test_alu_decode();
      stim_t s [$];
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33)});
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h20, 5'd2, 5'd1, 3'd5, 5'd4, 7'h33)});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      foreach (s[i]) begin
         drive(s[i].r, s[i].v, s[i].ins, s[i].fl);
         checks++;
         if (insn_ready_o !== exp_rdy) begin errors++; $display("FAIL alu_ready[%0d]: got %b want %b", i, insn_ready_o, exp_rdy); end
         tick();
         checks++;
         if (obs_x() !== exp_x()) begin errors++; $display("FAIL alu_x[%0d]: got %h want %h", i, obs_x(), exp_x()); end
         checks++;
         if (obs_m() !== exp_m()) begin errors++; $display("FAIL alu_m[%0d]: got %h want %h", i, obs_m(), exp_m()); end
         checks++;
         if (obs_w() !== exp_w()) begin errors++; $display("FAIL alu_w[%0d]: got %h want %h", i, obs_w(), exp_w()); end
         if (i == 0) begin
            checks++;
            if (x_alusel_o !== A_ADD || x_rs2sel_o !== 1'b0) begin
               errors++; $display("FAIL add_x: got alu %0d rs2sel %b want alu 0 rs2sel 0", x_alusel_o, x_rs2sel_o);
            end
         end
         if (i == 1) begin
            checks++;
            if (x_alusel_o !== A_SRA) begin errors++; $display("FAIL sra_x: got %0d want %0d", x_alusel_o, A_SRA); end
         end
         if (i == 2) begin
            checks++;
            if (w_regwren_o !== 1'b1 || w_wbsel_o !== WB_ALU || w_rd_o !== 5'd3) begin
               errors++; $display("FAIL add_w: got wren %b wb %0d rd %0d want 1 0 3", w_regwren_o, w_wbsel_o, w_rd_o);
            end
         end
      end
   endtask

   task automatic test_load_use(input logic [4:0] ld_rd);
      stim_t s [$];
      int    stalls;
      stalls = 0;
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd0, 5'd1, 3'd2, ld_rd, 7'h03)});
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd2, ld_rd, 3'd0, 5'd6, 7'h33)});
      if (ld_rd != 5'd0)
         s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd2, ld_rd, 3'd0, 5'd6, 7'h33)});
      for (int k = 0; k < 3; k++) s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      foreach (s[i]) begin
         drive(s[i].r, s[i].v, s[i].ins, s[i].fl);
         if (s[i].v && insn_ready_o === 1'b0) stalls++;
         checks++;
         if (insn_ready_o !== exp_rdy) begin errors++; $display("FAIL lu_ready[%0d]: got %b want %b", i, insn_ready_o, exp_rdy); end
         tick();
         checks++;
         if (obs_x() !== exp_x()) begin errors++; $display("FAIL lu_x[%0d]: got %h want %h", i, obs_x(), exp_x()); end
         checks++;
         if (obs_m() !== exp_m()) begin errors++; $display("FAIL lu_m[%0d]: got %h want %h", i, obs_m(), exp_m()); end
         checks++;
         if (obs_w() !== exp_w()) begin errors++; $display("FAIL lu_w[%0d]: got %h want %h", i, obs_w(), exp_w()); end
         if (i == 2 && ld_rd == 5'd0) begin
            checks++;
            if (w_valid_o !== 1'b1 || w_regwren_o !== 1'b0) begin
               errors++; $display("FAIL lw_x0_w: got valid %b wren %b want 1 0", w_valid_o, w_regwren_o);
            end
         end
      end
      checks++;
      if (stalls != ((ld_rd != 5'd0) ? 1 : 0)) begin
         errors++; $display("FAIL stall_cycles(rd=%0d): got %0d want %0d", ld_rd, stalls, (ld_rd != 5'd0) ? 1 : 0);
      end
   endtask

   task automatic test_flush();
      stim_t s [$];
      int    addi_in_w;
      addi_in_w = 0;
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63)});
      s.push_back('{1'b0, 1'b1, 1'b1, enc(7'h00, 5'd5, 5'd1, 3'd0, 5'd7, 7'h13)});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03)});
      s.push_back('{1'b0, 1'b1, 1'b1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33)});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      foreach (s[i]) begin
         drive(s[i].r, s[i].v, s[i].ins, s[i].fl);
         checks++;
         if (insn_ready_o !== exp_rdy) begin errors++; $display("FAIL fl_ready[%0d]: got %b want %b", i, insn_ready_o, exp_rdy); end
         if (s[i].fl) begin
            checks++;
            if (insn_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready[%0d]: got %b want 1", i, insn_ready_o); end
         end
         tick();
         if (w_valid_o === 1'b1 && w_rd_o === 5'd7) addi_in_w++;
         checks++;
         if (obs_x() !== exp_x()) begin errors++; $display("FAIL fl_x[%0d]: got %h want %h", i, obs_x(), exp_x()); end
         checks++;
         if (obs_m() !== exp_m()) begin errors++; $display("FAIL fl_m[%0d]: got %h want %h", i, obs_m(), exp_m()); end
         checks++;
         if (obs_w() !== exp_w()) begin errors++; $display("FAIL fl_w[%0d]: got %h want %h", i, obs_w(), exp_w()); end
         if (i == 1) begin
            checks++;
            if (m_valid_o !== 1'b1 || x_valid_o !== 1'b0) begin
               errors++; $display("FAIL beq_to_m: got m_valid %b x_valid %b want 1 0", m_valid_o, x_valid_o);
            end
         end
      end
      checks++;
      if (addi_in_w != 0) begin errors++; $display("FAIL flushed_addi_in_w: got %0d want 0", addi_in_w); end
   endtask

   task automatic test_illegal();
      stim_t s [$];
      logic  want;
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h7f)});
      for (int k = 0; k < 4; k++) s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      s.push_back('{1'b0, 1'b1, 1'b1, enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h7f)});
      for (int k = 0; k < 3; k++) s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      s.push_back('{1'b0, 1'b1, 1'b0, enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33)});
      for (int k = 0; k < 3; k++) s.push_back('{1'b0, 1'b0, 1'b0, 32'd0});
      foreach (s[i]) begin
         drive(s[i].r, s[i].v, s[i].ins, s[i].fl);
         checks++;
         if (insn_ready_o !== exp_rdy) begin errors++; $display("FAIL il_ready[%0d]: got %b want %b", i, insn_ready_o, exp_rdy); end
         tick();
         want = TRAP && (i == 2 || i == 11);
         checks++;
         if (illegal_o !== want) begin errors++; $display("FAIL illegal_pulse[%0d]: got %b want %b", i, illegal_o, want); end
         checks++;
         if (obs_x() !== exp_x()) begin errors++; $display("FAIL il_x[%0d]: got %h want %h", i, obs_x(), exp_x()); end
         checks++;
         if (obs_m() !== exp_m()) begin errors++; $display("FAIL il_m[%0d]: got %h want %h", i, obs_m(), exp_m()); end
         checks++;
         if (obs_w() !== exp_w()) begin errors++; $display("FAIL il_w[%0d]: got %h want %h", i, obs_w(), exp_w()); end
      end
   endtask

   task automatic test_random(input int n);
      logic [6:0]  ops [10];
      logic [6:0]  f7, op;
      logic [31:0] ins;
      logic        r, v, fl;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;  default: f7 = 7'($urandom);
         endcase
         op  = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         ins = enc(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                   5'($urandom_range(0, 3)), op);
         r   = ($urandom_range(0, 49) == 0);
         v   = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 9) == 0);
         drive(r, v, v ? ins : 32'd0, fl);
         checks++;
         if (insn_ready_o !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, insn_ready_o, exp_rdy); end
         tick();
         checks++;
         if (obs_x() !== exp_x()) begin errors++; $display("FAIL rnd_x[%0d]: got %h want %h", i, obs_x(), exp_x()); end
         checks++;
         if (obs_m() !== exp_m()) begin errors++; $display("FAIL rnd_m[%0d]: got %h want %h", i, obs_m(), exp_m()); end
         checks++;
         if (obs_w() !== exp_w()) begin errors++; $display("FAIL rnd_w[%0d]: got %h want %h", i, obs_w(), exp_w()); end
      end
   endtask

   initial begin
      reset = 1'b1; insn_valid_i = 1'b0; insn_i = '0; flush_i = 1'b0;
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      exp_rdy = 1'b0; cur_rst = 1'b1; cur_v = 1'b0; cur_fl = 1'b0; cur_ins = '0;
      test_reset();
      test_alu_decode();
      test_load_use(5'd5);
      test_load_use(5'd0);
      test_flush();
      test_illegal();
      test_random(600);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the combinational control decoder for the pd5 five-stage core.
- Decodes each accepted instruction into a control bundle, registers it into X, then carries the relevant fields through M and W.
- Owns load-use stall detection and flush squashing of younger instructions.
- Sits between the fetch/decode boundary and the datapath stage registers.

Parameters:
- DWIDTH, 32, instruction width.
- RWIDTH, 5, register-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- insn_i  in  DWIDTH  instruction from fetch
- insn_valid_i  in  1  insn_i valid
- insn_ready_o  out  1  ctrl_pipe accepts insn_i this cycle
- flush_i  in  1  redirect from X; squash younger instruction
- x_valid_o  out  1  X entry valid
- x_alusel_o  out  4  ALU select (constants.svh encoding)
- x_immsel_o  out  1  immediate used
- x_rs1sel_o  out  1  1 = PC as ALU operand A
- x_rs2sel_o  out  1  1 = immediate as ALU operand B
- x_pcsel_o  out  1  unconditional jump
- x_rs1_o, x_rs2_o, x_rd_o  out  RWIDTH  register addresses in X
- m_valid_o  out  1  M entry valid
- m_memren_o, m_memwren_o  out  1  memory read/write enable
- m_funct3_o  out  3  access size/sign
- m_rd_o  out  RWIDTH
- w_valid_o  out  1  W entry valid
- w_regwren_o  out  1  register write
- w_wbsel_o  out  2  wbALU / wbMEM / wbJAL
- w_rd_o  out  RWIDTH
- illegal_o  out  1  see Optional Feature

Behaviour:
- Reset (synchronous, active-high): all *_valid_o and every registered field are 0. insn_ready_o is 0 while reset is high. Reset mid-flight drops all three entries.
- Accept: accepted when insn_valid_i & insn_ready_o at a rising edge.
  - Accept at edge t: fields on x_* after t, m_* after t+1, w_* after t+2.
  - X, M and W always advance each cycle; there is no back-pressure downstream.
- Decode opcodes:
  - R-type: ALU op from funct3/funct7 (0x20 selects SUB/SRA); wbALU; regwren 1.
  - I-ALU: immsel 1, rs2sel 1; shifts use insn[31:25] (0x00 SLL/SRL, 0x20 SRA).
  - LOAD: ADD; immsel 1, rs2sel 1, memren 1, wbMEM, regwren 1.
  - STORE: ADD; immsel 1, rs2sel 1, memwren 1, regwren 0.
  - BRANCH: PCADD; immsel 1, rs1sel 1, rs2sel 1, regwren 0.
  - JAL: PCADD; rs1sel 1, rs2sel 1, pcsel 1, wbJAL, regwren 1.
  - JALR: ADD; rs2sel 1, pcsel 1, wbJAL, regwren 1.
  - LUI: ADD with rs1 forced to x0; rs2sel 1, regwren 1, memren 0.
  - AUIPC: ADD; rs1sel 1, rs2sel 1, regwren 1.
  - Unknown opcode: bubble encoding, all enables 0.
  - regwren is forced to 0 when rd = 0.
- Register use:
  - rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
- Load-use stall (combinational):
  - Condition: x_valid_o & X is LOAD & x_rd_o != 0 & x_rd_o matches a used rs of insn_i.
  - Response: insn_ready_o = 0, and X loads a bubble (valid 0, all enables 0).
  - Duration: exactly one cycle per hazard.
- Flush: flush_i at edge t means the instruction presented at t is consumed, if valid, and discarded.
  - X loads a bubble. The X instruction still advances to M.
  - insn_ready_o = 1 during flush. Flush has priority over stall.
- No valid input (insn_valid_i = 0): X loads a bubble. insn_ready_o = 1 when there is no stall and reset is low.
- Bubbles never assert memren, memwren or regwren at any stage.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An accepted unknown opcode, or an unsupported R/shift funct7, travels as an invalid-op entry with all enables 0.
  - illegal_o is a registered pulse, high for one cycle in the cycle that entry reaches W.
  - Flushed illegal instructions never raise illegal_o.
- Undefined: illegal_o is tied to 0. Such instructions become silent bubbles; unsupported funct7 decodes as ADD.

Test Plan:
- Reset: hold reset for 3 cycles with insn_valid_i = 1 → insn_ready_o = 0 and all valids/enables 0. First accept after release gives x_valid_o = 1 one cycle later.
- add x3,x1,x2 (0x002081B3) → x_alusel_o = ADD, x_rs2sel_o = 0. Two cycles later w_regwren_o = 1, w_wbsel_o = wbALU, w_rd_o = 3. sra (funct7 0x20) → SRA.
- lw x5,0(x1) then add x6,x5,x2 back-to-back → insn_ready_o = 0 for exactly 1 cycle; X shows a bubble, then the add. m_memren_o = 1 for the load only.
- Same pair with rd = x0 → no stall. For the lw, w_regwren_o = 0.
- beq in X with flush_i = 1 and addi presented → addi discarded (never reaches W), insn_ready_o = 1. beq reaches M with m_valid_o = 1. flush_i and stall together → flush wins, no stall cycle.
- opcode 0x7F with CTRL_ILLEGAL_TRAP_EN defined → illegal_o = 1 exactly 2 cycles after X (in W), no enables. Undefined → illegal_o stays 0.
